// File: rtl/act_array_pipe_pkg.sv
// act_pkg: activation mode encoding shared by the activation array pipeline.
package act_pkg;

  // Activation applied to every lane of one vector.
  typedef enum logic [1:0] {
    IDENT    = 2'd0,
    RELU     = 2'd1,
    LEAKY    = 2'd2,
    BWD_RELU = 2'd3
  } actMode_e;

  // Number of pipeline stages between acceptance and output.
  localparam int unsigned PIPE_DEPTH = 2;

endpackage

// File: rtl/act_array_pipe_lane.sv
// act_lane: purely combinational activation of one signed lane.
// y is the activated value. mask is 1 when x passed through unattenuated.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] aux,
  input  actMode_e              mode,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  mask
);

  logic                  xPos_s;
  logic                  xNonNeg_s;
  logic                  auxPos_s;
  logic [DATA_WIDTH-1:0] xLeak_s;

  // Sign tests done on raw bits: positive means sign clear and not all-zero.
  assign xNonNeg_s = ~x[DATA_WIDTH-1];
  assign xPos_s    = ~x[DATA_WIDTH-1] & (|x);
  assign auxPos_s  = ~aux[DATA_WIDTH-1] & (|aux);

  // Arithmetic shift floors toward negative infinity, so -1 stays -1.
  assign xLeak_s = DATA_WIDTH'($signed(x) >>> LEAK_SHIFT);

  // Select the lane result and derivative mask for the requested mode.
  always_comb begin
    y    = '0;
    mask = 1'b0;
    case (mode)
      IDENT: begin
        y    = x;
        mask = 1'b1;
      end
      RELU: begin
        if (xPos_s) begin
          y    = x;
          mask = 1'b1;
        end else begin
          y    = '0;
          mask = 1'b0;
        end
      end
      LEAKY: begin
        if (xNonNeg_s) begin
          y    = x;
          mask = 1'b1;
        end else begin
          y    = xLeak_s;
          mask = 1'b0;
        end
      end
      BWD_RELU: begin
        if (auxPos_s) begin
          y    = x;
          mask = 1'b1;
        end else begin
          y    = '0;
          mask = 1'b0;
        end
      end
      default: begin
        y    = '0;
        mask = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/act_array_pipe.sv
// act_array_pipe: two-stage valid/ready pipeline applying a per-vector
// activation across PACT lanes. Stage 1 holds lane results, mask and
// per-lane zero flags. Stage 2 holds the zero count and the output vector.
module act_array_pipe
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PACT       = 128,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_mode,
  input  logic [DATA_WIDTH*PACT-1:0] in_data,
  input  logic [DATA_WIDTH*PACT-1:0] in_aux,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACT-1:0] out_data,
  output logic [PACT-1:0]            out_mask,
  output logic [$clog2(PACT+1)-1:0]  out_zero_cnt,
  output logic                       out_last
);

  localparam int CW = $clog2(PACT+1);
  localparam int VW = DATA_WIDTH*PACT;

  actMode_e        inMode_s;
  logic [VW-1:0]   laneY_s;
  logic [PACT-1:0] laneMask_s;
  logic [PACT-1:0] laneZero_s;

  logic            s1Valid_r;
  logic [VW-1:0]   s1Data_r;
  logic [PACT-1:0] s1Mask_r;
  logic [PACT-1:0] s1Zero_r;
  logic            s1Last_r;

  logic            s1Load_s;
  logic            s2Load_s;
  logic [CW-1:0]   zeroCnt_s;

  assign inMode_s = actMode_e'(in_mode);

  // One combinational activation lane per element of the vector.
  for (genvar g = 0; g < PACT; g++) begin : gLane
    act_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) uLane (
      .x    (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .aux  (in_aux[g*DATA_WIDTH +: DATA_WIDTH]),
      .mode (inMode_s),
      .y    (laneY_s[g*DATA_WIDTH +: DATA_WIDTH]),
      .mask (laneMask_s[g])
    );
    assign laneZero_s[g] = ~(|laneY_s[g*DATA_WIDTH +: DATA_WIDTH]);
  end

  // A stage may load when it is empty or its contents move on this cycle.
  assign s2Load_s = ~out_valid | out_ready;
  assign s1Load_s = ~s1Valid_r | s2Load_s;
  assign in_ready = rst & s1Load_s;

  // Popcount of the registered lane-zero flags feeding stage 2.
  always_comb begin
    zeroCnt_s = '0;
    for (int i = 0; i < PACT; i++) begin
      zeroCnt_s = zeroCnt_s + CW'(s1Zero_r[i]);
    end
  end

  // Stage 1: capture lane results of an accepted vector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1Valid_r <= 1'b0;
      s1Data_r  <= '0;
      s1Mask_r  <= '0;
      s1Zero_r  <= '0;
      s1Last_r  <= 1'b0;
    end else if (s1Load_s) begin
      s1Valid_r <= in_valid;
      if (in_valid) begin
        s1Data_r <= laneY_s;
        s1Mask_r <= laneMask_s;
        s1Zero_r <= laneZero_s;
        s1Last_r <= in_last;
      end
    end
  end

  // Stage 2: register the zero count and present the vector downstream.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_mask     <= '0;
      out_zero_cnt <= '0;
      out_last     <= 1'b0;
    end else if (s2Load_s) begin
      out_valid <= s1Valid_r;
      if (s1Valid_r) begin
        out_data     <= s1Data_r;
        out_mask     <= s1Mask_r;
        out_zero_cnt <= zeroCnt_s;
        out_last     <= s1Last_r;
      end
    end
  end

endmodule

// File: tb/tb_act_array_pipe.sv
// Directed self-checking bench for act_array_pipe (16-bit lanes, 4 lanes).
module tb_act_array_pipe;

  localparam int DW = 16;
  localparam int P  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [63:0]   in_data;
  logic [63:0]   in_aux;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic [3:0]    out_mask;
  logic [CW-1:0] out_zero_cnt;
  logic          out_last;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] data;
    logic [63:0] aux;
    logic        last;
    logic [63:0] expData;
    logic [3:0]  expMask;
    logic [2:0]  expZc;
  } vec_t;

  vec_t tbl [7];
  vec_t sq  [6];

  int          si, ri, c;
  logic        acc, xfer;
  logic [63:0] heldData;

  act_array_pipe #(.DATA_WIDTH(DW), .PACT(P), .LEAK_SHIFT(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mode      (in_mode),
    .in_data      (in_data),
    .in_aux       (in_aux),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_mask     (out_mask),
    .out_zero_cnt (out_zero_cnt),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pack four lanes, lane 0 given first.
  function automatic logic [63:0] pk(input int a, input int b, input int d2, input int d3);
    return {d3[15:0], d2[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chkOut(input string tag, input vec_t v);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"},  out_data, v.expData);
    chk({tag, "_mask"},  64'(out_mask), 64'(v.expMask));
    chk({tag, "_zc"},    64'(out_zero_cnt), 64'(v.expZc));
    chk({tag, "_last"},  64'(out_last), 64'(v.last));
  endtask

  initial begin
    tbl[0] = '{2'd1, pk(5, -3, 0, -32768), 64'd0, 1'b0, pk(5, 0, 0, 0), 4'b0001, 3'd3};
    tbl[1] = '{2'd2, pk(-8, -1, 7, -16), 64'd0, 1'b1, pk(-1, -1, 7, -2), 4'b0100, 3'd0};
    tbl[2] = '{2'd3, pk(10, 20, 30, 40), pk(1, -1, 0, 2), 1'b0, pk(10, 0, 0, 40), 4'b1001, 3'd2};
    tbl[3] = '{2'd0, pk(-32768, 32767, 0, 1), 64'd0, 1'b1, pk(-32768, 32767, 0, 1), 4'b1111, 3'd1};
    tbl[4] = '{2'd2, pk(-32768, 0, -9, 8), 64'd0, 1'b0, pk(-4096, 0, -2, 8), 4'b1010, 3'd1};
    tbl[5] = '{2'd3, pk(0, -5, 3, 7), pk(5, 5, -32768, 0), 1'b1, pk(0, -5, 0, 0), 4'b0011, 3'd3};
    tbl[6] = '{2'd1, pk(1, -1, 32767, 0), 64'd0, 1'b0, pk(1, 0, 32767, 0), 4'b0101, 3'd2};

    // Streaming vectors: modes cycle 0..3, lane 0 tags the vector order.
    for (int k = 0; k < 6; k++) begin
      sq[k].mode = 2'(k % 4);
      sq[k].data = pk(11 + k, -12, 0, -40);
      sq[k].aux  = pk(1, 3, 0, 1);
      sq[k].last = (k == 5);
      case (k % 4)
        0: begin sq[k].expData = pk(11 + k, -12, 0, -40); sq[k].expMask = 4'b1111; sq[k].expZc = 3'd1; end
        1: begin sq[k].expData = pk(11 + k, 0, 0, 0);     sq[k].expMask = 4'b0001; sq[k].expZc = 3'd3; end
        2: begin sq[k].expData = pk(11 + k, -2, 0, -5);   sq[k].expMask = 4'b0101; sq[k].expZc = 3'd1; end
        default: begin sq[k].expData = pk(11 + k, -12, 0, -40); sq[k].expMask = 4'b1011; sq[k].expZc = 3'd1; end
      endcase
    end

    rst = 1'b0; in_valid = 1'b0; in_mode = 2'd0; in_data = 64'd0;
    in_aux = 64'd0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_mask", 64'(out_mask), 64'd0);
    chk("rst_out_zc", 64'(out_zero_cnt), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Table vectors, one at a time, latency checked per vector.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_mode = tbl[i].mode; in_data = tbl[i].data;
      in_aux = tbl[i].aux; in_last = tbl[i].last;
      #1 chk("tbl_in_ready", 64'(in_ready), 64'd1);
      cyc();
      in_valid = 1'b0;
      #1 chk("tbl_lat1_valid", 64'(out_valid), 64'd0);
      cyc();
      chkOut($sformatf("tbl%0d", i), tbl[i]);
    end
    cyc();

    // Back-to-back alternating modes with a downstream stall in cycles 3..6.
    si = 0; ri = 0; c = 0; heldData = 64'd0;
    while ((si < 6 || ri < 6) && c < 40) begin
      c++;
      out_ready = !(c >= 3 && c <= 6);
      if (si < 6) begin
        in_valid = 1'b1; in_mode = sq[si].mode; in_data = sq[si].data;
        in_aux = sq[si].aux; in_last = sq[si].last;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      #1;
      if (c == 4) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (c >= 4 && c <= 6) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", out_data, heldData);
      end
      heldData = out_data;
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        if (ri < 6) chkOut($sformatf("seq%0d", ri), sq[ri]);
        else chk("seq_extra_output", 64'(out_valid), 64'd0);
        ri++;
      end
      cyc();
      if (acc) si++;
    end
    chk("seq_received", 64'(ri), 64'd6);
    chk("seq_sent", 64'(si), 64'd6);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    chk("seq_drained", 64'(out_valid), 64'd0);

    // Reset while two vectors are in flight and none has transferred.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'd0; in_data = pk(100, -100, 0, 1); in_last = 1'b1;
    #1 chk("flight_a_ready", 64'(in_ready), 64'd1);
    cyc();
    in_mode = 2'd1; in_data = pk(200, 3, 4, 5);
    #1 chk("flight_b_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    #1 chk("flight_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b0;
    #1 chk("in_reset_ready", 64'(in_ready), 64'd0);
    cyc();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_mask", 64'(out_mask), 64'd0);
    chk("mid_rst_zc", 64'(out_zero_cnt), 64'd0);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    rst = 1'b1; out_ready = 1'b1;
    #1 chk("mid_rst_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("no_ghost", 64'(out_valid), 64'd0);
    end
    tbl[0] = '{2'd1, pk(-7, 9, 0, 3), 64'd0, 1'b1, pk(0, 9, 0, 3), 4'b1010, 3'd2};
    in_valid = 1'b1; in_mode = tbl[0].mode; in_data = tbl[0].data; in_last = 1'b1;
    #1 chk("after_rst_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0; in_last = 1'b0;
    #1 chk("after_rst_lat1", 64'(out_valid), 64'd0);
    cyc();
    chkOut("after_rst", tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
